// File: rtl/aes_iter_core.sv
// Iterative FIPS-197 AES encryptor: one round per clock, round keys derived on the fly from a key window.
// Optional build macro AES_BLOCK_CNT_EN adds output blk_cnt, a wrapping count of output handshakes.
module aes_iter_core #(
  parameter  int KEY_BITS = 128,
  localparam int NR       = (KEY_BITS == 256) ? 14 : 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
`ifdef AES_BLOCK_CNT_EN
  output logic [31:0]         blk_cnt,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] NR_W = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the MSB byte, so byte b starts at bit 8*(255-b)+7.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    y = 128'd0;
    for (int i = 0; i < 16; i++) begin
      y[8*i +: 8] = sbox(x[8*i +: 8]);
    end
    return y;
  endfunction

  // Byte (r,c) lives at index r+4c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return y;
  endfunction

  state_e                state_q, state_d;
  logic [127:0]          blk_q, blk_d;
  logic [127:0]          dout_q, dout_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [7:0]            rcon_q, rcon_d;
  logic [3:0]            round_q, round_d;

  logic [127:0]          sr_s;
  logic [127:0]          mix_s;
  logic [127:0]          rk_s;
  logic [KEY_BITS-1:0]   key_next_s;
  logic                  rcon_step_s;
  logic                  accept_s;

  assign sr_s  = shift_rows(sub_bytes(blk_q));
  assign mix_s = mix_columns(sr_s);

  generate
    if (KEY_BITS == 256) begin : g_k256
      // Window holds {RK[r-1], RK[r]}; RK[r+1] is built from it, with the Rcon step on even key indices.
      logic [31:0] temp_s, w0_s, w1_s, w2_s, w3_s;
      assign rcon_step_s = round_q[0];
      assign temp_s = round_q[0] ? (sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h000000})
                                 : sub_word(key_q[31:0]);
      assign w0_s = key_q[255:224] ^ temp_s;
      assign w1_s = key_q[223:192] ^ w0_s;
      assign w2_s = key_q[191:160] ^ w1_s;
      assign w3_s = key_q[159:128] ^ w2_s;
      assign rk_s       = key_q[127:0];
      assign key_next_s = {key_q[127:0], w0_s, w1_s, w2_s, w3_s};
    end else begin : g_k128
      // Window holds RK[r-1]; RK[r] is derived this cycle and written back.
      logic [31:0] temp_s, w0_s, w1_s, w2_s, w3_s;
      assign rcon_step_s = 1'b1;
      assign temp_s = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h000000};
      assign w0_s = key_q[127:96] ^ temp_s;
      assign w1_s = key_q[95:64]  ^ w0_s;
      assign w2_s = key_q[63:32]  ^ w1_s;
      assign w3_s = key_q[31:0]   ^ w2_s;
      assign rk_s       = {w0_s, w1_s, w2_s, w3_s};
      assign key_next_s = rk_s;
    end
  endgenerate

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign data_out  = dout_q;

  // Next-state, round datapath and block capture.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    dout_d  = dout_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = S_RUN;
          blk_d   = data_in ^ key[KEY_BITS-1 -: 128];
          key_d   = key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        key_d  = key_next_s;
        rcon_d = rcon_step_s ? xtime(rcon_q) : rcon_q;
        if (round_q == NR_W) begin
          state_d = S_DONE;
          blk_d   = sr_s ^ rk_s;
          dout_d  = sr_s ^ rk_s;
          round_d = 4'd0;
        end else begin
          blk_d   = mix_s ^ rk_s;
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= 128'd0;
      dout_q  <= 128'd0;
      key_q   <= {KEY_BITS{1'b0}};
      rcon_q  <= 8'h00;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      dout_q  <= dout_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

`ifdef AES_BLOCK_CNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  assign blk_cnt_d = (out_valid && out_ready) ? (blk_cnt_q + 32'd1) : blk_cnt_q;
  assign blk_cnt   = blk_cnt_q;

  // Output handshake counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt_q <= 32'd0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: one AES-128 and one AES-256 instance checked
// against known-answer vectors and an independent byte-matrix AES model.
module tb_aes_iter_core;

  localparam logic [127:0] KAT_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KAT_K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_data_in, a_key, a_data_out;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_data_in, b_data_out;
  logic [255:0] b_key;
`ifdef AES_BLOCK_CNT_EN
  logic [31:0]  a_blk_cnt, b_blk_cnt;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           last_hs_a = -1;
  logic [127:0] exp_a[$];
  logic [127:0] exp_b[$];
  logic [7:0]   sbox_t [256];

  aes_iter_core #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_out(a_data_out),
`ifdef AES_BLOCK_CNT_EN
    .blk_cnt(a_blk_cnt),
`endif
    .busy(a_busy)
  );

  aes_iter_core #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out),
`ifdef AES_BLOCK_CNT_EN
    .blk_cnt(b_blk_cnt),
`endif
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Reference encryption with a fully stored key schedule; key is MSB-aligned in k.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] ct;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    ct = 128'd0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
        if (rnd < nr) begin
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
        end
        for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ct[127-8*(r+4*c) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: every output handshake pops and compares the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      last_hs_a <= cyc;
      if (exp_a.size() == 0) check_eq("a_spurious_out", {127'd0, a_out_valid}, 128'd0);
      else check_eq("a_ct", a_data_out, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) check_eq("b_spurious_out", {127'd0, b_out_valid}, 128'd0);
      else check_eq("b_ct", b_data_out, exp_b.pop_front());
    end
  end

  task automatic send_a(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e,
                        output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    a_data_in = d; a_key = k; a_in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (a_in_ready) begin got = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    check_eq("a_accept", {127'd0, got}, 128'd1);
    if (got) exp_a.push_back(e);
    a_in_valid = 1'b0; a_data_in = rnd128(); a_key = rnd128();
  endtask

  task automatic send_b(input logic [127:0] d, input logic [255:0] k, input logic [127:0] e);
    bit got;
    got = 1'b0;
    b_data_in = d; b_key = k; b_in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (b_in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("b_accept", {127'd0, got}, 128'd1);
    if (got) exp_b.push_back(e);
    b_in_valid = 1'b0; b_data_in = rnd128(); b_key = {rnd128(), rnd128()};
  endtask

  // Edges from the accept edge until out_valid is first seen (capped at 40).
  task automatic wait_out(input bit sel_b, output int k);
    bit seen;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      k++;
      seen = sel_b ? b_out_valid : a_out_valid;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check_eq("drain_a", 128'(exp_a.size()), 128'd0);
    check_eq("drain_b", 128'(exp_b.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] d, d2, k, k2, e, e2;
    logic [255:0] kb;
    int acc1, acc2, lat, pulses;

    build_sbox();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_data_in = 128'd0; a_key = 128'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = 128'd0; b_key = 256'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_out_valid", {127'd0, a_out_valid}, 128'd0);
    check_eq("rst_a_busy", {127'd0, a_busy}, 128'd0);
    check_eq("rst_a_data_out", a_data_out, 128'd0);
    check_eq("rst_b_out_valid", {127'd0, b_out_valid}, 128'd0);
    check_eq("rst_b_data_out", b_data_out, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_a_in_ready", {127'd0, a_in_ready}, 128'd1);
    check_eq("rst_b_in_ready", {127'd0, b_in_ready}, 128'd1);
    @(posedge clk); #1;

    // Known-answer vectors and first-output latency.
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    send_a(KAT_PT, KAT_K128, KAT_CT128, acc1);
    @(negedge clk);
    check_eq("a_busy_run", {127'd0, a_busy}, 128'd1);
    wait_out(1'b0, lat);
    check_eq("a_latency", 128'(lat), 128'd10);
    drain();
    send_b(KAT_PT, KAT_K256, KAT_CT256);
    wait_out(1'b1, lat);
    check_eq("b_latency", 128'(lat), 128'd14);
    drain();

    // Output stall: result holds while inputs churn.
    a_out_ready = 1'b0;
    d = rnd128(); k = rnd128();
    e = aes_ref(d, {k, 128'd0}, 4);
    send_a(d, k, e, acc1);
    wait_out(1'b0, lat);
    check_eq("a_latency_stall", 128'(lat), 128'd10);
    for (int i = 0; i < 5; i++) begin
      a_data_in = rnd128(); a_key = rnd128(); a_in_valid = 1'b1;
      @(negedge clk);
      check_eq("stall_valid", {127'd0, a_out_valid}, 128'd1);
      check_eq("stall_data", a_data_out, e);
      check_eq("stall_in_ready", {127'd0, a_in_ready}, 128'd0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    drain();

    // Back-to-back: second accept coincides with the first output handshake.
    d = rnd128(); k = rnd128(); d2 = rnd128(); k2 = rnd128();
    e = aes_ref(d, {k, 128'd0}, 4);
    e2 = aes_ref(d2, {k2, 128'd0}, 4);
    send_a(d, k, e, acc1);
    send_a(d2, k2, e2, acc2);
    check_eq("b2b_gap", 128'(acc2 - acc1), 128'd11);
    check_eq("b2b_same_edge", 128'(last_hs_a), 128'(acc2));
    drain();

    // Reset while round 5 is in flight abandons the block.
    d = rnd128(); k = rnd128();
    send_a(d, k, aes_ref(d, {k, 128'd0}, 4), acc1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(exp_a.pop_back());
    @(negedge clk);
    check_eq("midrst_in_ready", {127'd0, a_in_ready}, 128'd1);
    check_eq("midrst_busy", {127'd0, a_busy}, 128'd0);
    check_eq("midrst_data_out", a_data_out, 128'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_out_valid) pulses++;
    end
    check_eq("midrst_no_pulse", 128'(pulses), 128'd0);
    @(posedge clk); #1;
    d = rnd128(); k = rnd128();
    send_a(d, k, aes_ref(d, {k, 128'd0}, 4), acc1);
    drain();

    // Random blocks on both key sizes.
    for (int n = 0; n < 4; n++) begin
      d = rnd128(); k = rnd128();
      send_a(d, k, aes_ref(d, {k, 128'd0}, 4), acc1);
      d = rnd128(); kb = {rnd128(), rnd128()};
      send_b(d, kb, aes_ref(d, kb, 8));
      drain();
    end

`ifdef AES_BLOCK_CNT_EN
    @(negedge clk);
    force dut_a.blk_cnt_q = 32'hffffffff;
    @(posedge clk); #1;
    release dut_a.blk_cnt_q;
    send_a(KAT_PT, KAT_K128, KAT_CT128, acc1);
    drain();
    @(negedge clk);
    check_eq("blk_cnt_wrap", {96'd0, a_blk_cnt}, 128'd0);
    @(posedge clk); #1;
    send_a(KAT_PT, KAT_K128, KAT_CT128, acc1);
    drain();
    @(negedge clk);
    check_eq("blk_cnt_inc", {96'd0, a_blk_cnt}, 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
